// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: load-use stalls, branch flushes and data-memory wait freezes.
// Define HAZARD_PERF_CNT_EN to add saturating load-use / memory stall counters.
module hazard_stall_ctrl #(
    parameter int unsigned MAX_WAIT = 15,
    parameter int unsigned WAIT_W   = 4
`ifdef HAZARD_PERF_CNT_EN
    ,
    parameter int unsigned PERF_W   = 16
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       idex_memread,
    input  logic [4:0] idex_rt,
    input  logic [4:0] ifid_rs,
    input  logic [4:0] ifid_rt,
    input  logic       ifid_uses_rt,
    input  logic       branch_taken,
    input  logic       exmem_memread,
    input  logic       exmem_memwrite,
    input  logic       mem_ready,
    output logic       dmem_req,
    output logic       pc_wr_en,
    output logic       ifid_en,
    output logic       ifid_flush,
    output logic       idex_en,
    output logic       idex_flush,
    output logic       exmem_en,
    output logic       memwb_bubble,
    output logic       mem_timeout
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0] perf_lu_stalls,
    output logic [PERF_W-1:0] perf_mem_stalls
`endif
);

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic [WAIT_W-1:0]   w_wait_cnt_nxt;
    logic                r_mem_timeout;
    logic                w_timeout_set;
    logic                w_mem_op;
    logic                w_load_use;

    assign w_mem_op   = exmem_memread | exmem_memwrite;
    assign w_load_use = idex_memread & (idex_rt != 5'd0) &
                        ((idex_rt == ifid_rs) | (ifid_uses_rt & (idex_rt == ifid_rt)));

    assign mem_timeout = r_mem_timeout;

    // State, wait counter and sticky timeout flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_RUN;
            r_wait_cnt    <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            if (w_timeout_set) begin
                r_mem_timeout <= 1'b1;
            end
        end
    end

    // Next-state and pipeline control; reset overrides every output at the end
    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_timeout_set  = 1'b0;
        dmem_req       = 1'b0;
        pc_wr_en       = 1'b1;
        ifid_en        = 1'b1;
        ifid_flush     = 1'b0;
        idex_en        = 1'b1;
        idex_flush     = 1'b0;
        exmem_en       = 1'b1;
        memwb_bubble   = 1'b0;

        case (r_state)
            ST_RUN: begin
                dmem_req = w_mem_op;
                if (w_mem_op & ~mem_ready) begin
                    pc_wr_en       = 1'b0;
                    ifid_en        = 1'b0;
                    idex_en        = 1'b0;
                    exmem_en       = 1'b0;
                    memwb_bubble   = 1'b1;
                    w_state_nxt    = ST_MEM_WAIT;
                    w_wait_cnt_nxt = WAIT_W'(1);
                end else if (w_load_use) begin
                    pc_wr_en   = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                end else if (branch_taken) begin
                    ifid_flush = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                dmem_req = 1'b1;
                if (mem_ready) begin
                    w_state_nxt    = ST_RUN;
                    w_wait_cnt_nxt = '0;
                end else if (r_wait_cnt == WAIT_W'(MAX_WAIT)) begin
                    // Forced release: pipeline moves on but the stale MEM result is dropped
                    memwb_bubble   = 1'b1;
                    w_timeout_set  = 1'b1;
                    w_state_nxt    = ST_RUN;
                    w_wait_cnt_nxt = '0;
                end else begin
                    pc_wr_en       = 1'b0;
                    ifid_en        = 1'b0;
                    idex_en        = 1'b0;
                    exmem_en       = 1'b0;
                    memwb_bubble   = 1'b1;
                    w_wait_cnt_nxt = r_wait_cnt + WAIT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase

        if (reset) begin
            dmem_req     = 1'b0;
            pc_wr_en     = 1'b0;
            ifid_en      = 1'b0;
            ifid_flush   = 1'b1;
            idex_en      = 1'b0;
            idex_flush   = 1'b1;
            exmem_en     = 1'b0;
            memwb_bubble = 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic                w_lu_path;
    logic [PERF_W-1:0]   r_perf_lu;
    logic [PERF_W-1:0]   r_perf_mem;

    assign w_lu_path = ~reset & (r_state == ST_RUN) & ~(w_mem_op & ~mem_ready) & w_load_use;

    // Saturating stall counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_lu  <= '0;
            r_perf_mem <= '0;
        end else begin
            if (w_lu_path && !(&r_perf_lu)) begin
                r_perf_lu <= r_perf_lu + PERF_W'(1);
            end
            if (!exmem_en && !(&r_perf_mem)) begin
                r_perf_mem <= r_perf_mem + PERF_W'(1);
            end
        end
    end

    assign perf_lu_stalls  = r_perf_lu;
    assign perf_mem_stalls = r_perf_mem;
`endif

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core.
- Drives write-enables, flushes and bubble-inserts for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Resolves load-use hazards, taken-branch/jump flushes, and multi-cycle data-memory accesses with a ready handshake and timeout.
- Sits beside the datapath; its outputs feed only the pipeline registers' enable, flush and bubble inputs.

Parameters:
- MAX_WAIT, 15: maximum data-memory wait cycles before forced release; must be at least 1.
- WAIT_W, 4: width of the wait counter; must satisfy 2^WAIT_W > MAX_WAIT.
- PERF_W, 16: width of the performance counters (optional feature only).

Ports:
- clk, in, 1: single clock, rising edge.
- reset, in, 1: synchronous, active-high.
- idex_memread, in, 1: the instruction in EX is a load.
- idex_rt, in, 5: load destination register in EX.
- ifid_rs, in, 5: rs of the instruction in ID.
- ifid_rt, in, 5: rt of the instruction in ID.
- ifid_uses_rt, in, 1: the ID instruction reads rt.
- branch_taken, in, 1: branch or jump resolved taken in ID.
- exmem_memread, in, 1: load in MEM.
- exmem_memwrite, in, 1: store in MEM.
- mem_ready, in, 1: data memory completes its access this cycle.
- dmem_req, out, 1: data memory request strobe.
- pc_wr_en, out, 1: PC register write enable.
- ifid_en, out, 1: IF/ID write enable.
- ifid_flush, out, 1: IF/ID loads a NOP.
- idex_en, out, 1: ID/EX write enable.
- idex_flush, out, 1: ID/EX loads a bubble.
- exmem_en, out, 1: EX/MEM write enable.
- memwb_bubble, out, 1: MEM/WB loads RegWr=0 and MemtoReg=00.
- mem_timeout, out, 1: sticky memory-timeout error flag.

Behaviour:
- Clocking and reset: clk is the only clock. Reset is synchronous and active-high. State, counters and mem_timeout update on the rising clk edge only.
- Reset values (while reset=1):
  - state=RUN, wait_cnt=0, mem_timeout=0.
  - Outputs forced: all enables=0, ifid_flush=1, idex_flush=1, memwb_bubble=1, dmem_req=0.
  - A reset asserted during MEM_WAIT aborts the access; dmem_req drops in the same cycle.
- Output timing: all outputs except mem_timeout are combinational from state and inputs. mem_timeout is registered.
- mem_op = exmem_memread | exmem_memwrite.
- load_use = idex_memread & (idex_rt != 0) & ((idex_rt == ifid_rs) | (ifid_uses_rt & (idex_rt == ifid_rt))).
- FSM states: RUN, MEM_WAIT.
- RUN:
  - dmem_req = mem_op.
  - If mem_op & ~mem_ready:
    - Freeze: pc_wr_en, ifid_en, idex_en and exmem_en = 0.
    - memwb_bubble=1.
    - Next state MEM_WAIT; wait_cnt <= 1.
  - Else if load_use:
    - pc_wr_en=0, ifid_en=0.
    - idex_flush=1, idex_en=1.
    - exmem_en=1.
    - branch_taken is ignored (the branch re-evaluates next cycle).
  - Else if branch_taken: all enables=1, ifid_flush=1.
  - Else: all enables=1, no flush, memwb_bubble=0.
- MEM_WAIT:
  - dmem_req=1 throughout; the full freeze is held; memwb_bubble=1.
  - load_use and branch_taken are ignored.
  - On mem_ready=1:
    - memwb_bubble=0 and all enables=1 that cycle, so the MEM result enters MEM/WB.
    - Next state RUN; wait_cnt <= 0.
  - On mem_ready=0 with wait_cnt==MAX_WAIT (forced release):
    - mem_timeout <= 1; it is sticky until reset.
    - Release exactly as for mem_ready, except memwb_bubble stays 1, so the access result is discarded.
    - Next state RUN.
  - Otherwise: wait_cnt <= wait_cnt + 1.
- Priority: memory freeze > load-use > branch flush.
- Zero-wait access: mem_op with mem_ready=1 in RUN never stalls.
- Back-to-back memory ops: the release cycle out of MEM_WAIT returns to RUN. A new mem_op one cycle later is handled normally.
- Flush outputs are never asserted together with their own register's enable=0, except during reset.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- When defined, two outputs are added, each PERF_W wide and saturating:
  - perf_lu_stalls: counts RUN cycles taking the load-use path.
  - perf_mem_stalls: counts cycles where exmem_en=0 outside reset.
  - Both clear on reset.
- When undefined: the ports and counters are absent, and the remaining behaviour is identical.

Test Plan:
- Reset held 2 cycles -> all enables 0, ifid_flush=idex_flush=memwb_bubble=1, dmem_req=0, mem_timeout=0. First cycle after release with no hazards -> all enables 1.
- idex_memread=1, idex_rt=8, ifid_rs=8 -> exactly one cycle of pc_wr_en=0, ifid_en=0, idex_flush=1. With idex_rt=0 -> no stall.
- Load-use and branch_taken=1 in the same cycle -> stall only, ifid_flush=0. Next cycle with branch_taken=1 and no load-use -> ifid_flush=1.
- exmem_memread=1, mem_ready low for 3 cycles then high -> freeze for 3 cycles with memwb_bubble=1 and dmem_req=1. The 4th cycle gives all enables 1 and memwb_bubble=0. State returns to RUN.
- mem_ready held low with MAX_WAIT=15 -> forced release on the 16th cycle of the access with memwb_bubble=1. mem_timeout=1 from the next cycle and stays 1 until reset.
- Reset asserted in the middle of MEM_WAIT -> dmem_req=0 in the same cycle; state RUN and wait_cnt=0 after the edge.
